conv_accum_tree: RTL and testbench
==================================

Name: conv_accum_tree

Overview:
Parametrised, fully pipelined signed/unsigned adder tree for the convolution datapath. It sums KERNEL_SIZE PE products, adds a per-beat bias, applies a rounding right shift, optional ReLU, and saturation to a pixel-width output. It has a valid/ready handshake with backpressure. It sits between the PE array and the output line buffer.

Parameters:
KERNEL_SIZE, 9, number of products summed per beat (>=2)
DATA_WIDTH, 8, input pixel width
WEIGHT_WIDTH, 8, kernel weight width
BIAS_WIDTH, 16, bias width (same signedness as SIGNED)
SHIFT_WIDTH, 5, width of the shift-amount field
OUT_WIDTH, 8, saturated output width
SIGNED, 1, 1 = two's-complement products/bias/output; 0 = unsigned

Ports:
clk  in  1  clock
rstn  in  1  synchronous, active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  block accepts beat this cycle
in_data  in  KERNEL_SIZE*PROD_W  packed products, product j at bits [(j+1)*PROD_W-1 -: PROD_W]
in_bias  in  BIAS_WIDTH  bias for this beat
in_shift  in  SHIFT_WIDTH  right-shift amount for this beat
in_relu  in  1  clamp negatives to 0 for this beat (ignored when SIGNED=0)
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  OUT_WIDTH  rounded, shifted, saturated result
out_sum  out  ACC_W  raw sum plus bias, before shift
out_sat  out  1  saturation clamp was applied to out_data

Behaviour:
- Widths: PROD_W=DATA_WIDTH+WEIGHT_WIDTH; SUM_W=PROD_W+$clog2(KERNEL_SIZE); ACC_W=max(SUM_W,BIAS_WIDTH)+1; LEVELS=$clog2(KERNEL_SIZE). All operands are sign-extended (SIGNED=1) or zero-extended (SIGNED=0) before adding; no intermediate overflow is possible.
- Pipeline: stage 0 registers the products. Then LEVELS registered pairwise-add levels run; an odd leftover operand at any level passes through registered unchanged. A final post-process stage follows. No-stall latency is LEVELS+2 cycles from the accepting edge to out_valid (6 for K=9).
- Sideband: bias, shift and relu are captured with the beat at stage 0 and travel with it. Bias is added at the last tree level.
- Post-process: acc=sum+bias, and out_sum=acc. If shift>0, r=(acc+(1<<(shift-1)))>>>shift (arithmetic shift, round half toward +inf); if shift=0, r=acc. If shift>=ACC_W, r = 0 for non-negative acc and -1 for negative acc.
- ReLU: if SIGNED and relu and r<0, r=0 with out_sat=0.
- Saturation: clamp to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] when SIGNED, or [0, 2^OUT_WIDTH-1] when unsigned. out_sat=1 only when a clamp altered the value.
- Handshake: a global stall applies. advance = !out_valid || out_ready, and in_ready = advance && rstn.
  - A beat is accepted when in_valid && in_ready.
  - When advance=0, every stage, including per-stage valid bits, holds.
  - Bubbles propagate as valid=0 stages.
  - Output registers change only on advance. out_data/out_sum/out_sat stay stable while out_valid && !out_ready.
  - No beat is dropped or duplicated. Throughput is 1 beat/cycle when out_ready=1.
- in_data is ignored when in_valid=0. Data registers are loaded only for valid beats; bubble content is don't-care and never presented with out_valid=1.
- Reset (rstn=0 at posedge):
  - Every stage valid bit, out_valid, out_data, out_sum and out_sat become 0.
  - In-flight beats are discarded, including on a mid-stream reset.
  - in_ready=0 while rstn=0.
  - The first beat after release appears exactly LEVELS+2 cycles after acceptance.
- Simultaneous out_ready=1 with an in_valid acceptance in the same cycle is a normal shift; the pipeline stays full.

Test Plan:
1. K=9, signed, all products 1, bias 0, shift 0, out_ready=1 -> out_sum=9, out_data=9, out_sat=0, out_valid exactly 6 cycles after acceptance.
2. All products 16'h4000 (16384), bias 0, shift 0 -> out_sum=147456, out_data=127, out_sat=1. All products 16'h8000 (-32768) -> out_data=-128, out_sat=1.
3. Rounding: acc=6, shift 2 -> 2; acc=5, shift 2 -> 1; acc=-6, shift 2 -> -1; acc=-7, shift 1 -> -3; bias -10 with products summing 4 -> out_sum=-6.
4. ReLU: acc=-20, relu=1 -> out_data=0, out_sat=0. Same beat with relu=0 -> out_data=-20.
5. Backpressure: stream 12 beats with distinct sums and hold out_ready=0 for 3 cycles twice mid-stream -> all 12 results in order, none duplicated. in_ready=0 exactly while out_valid && !out_ready. Outputs stay stable during stalls.
6. Reset after 3 beats accepted and in flight -> out_valid=0 the cycle after reset and none of the 3 beats emerge. A new beat after release -> correct result at latency 6.

Source files
------------

// File: rtl/conv_accum_tree.sv
// Pipelined adder tree for the convolution datapath: sums KERNEL_SIZE products,
// adds bias, then applies a rounding shift, optional ReLU and saturation.
module conv_accum_tree #(
   parameter int unsigned KERNEL_SIZE  = 9,
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned WEIGHT_WIDTH = 8,
   parameter int unsigned BIAS_WIDTH   = 16,
   parameter int unsigned SHIFT_WIDTH  = 5,
   parameter int unsigned OUT_WIDTH    = 8,
   parameter bit          SIGNED       = 1'b1,
   localparam int unsigned PROD_W = DATA_WIDTH + WEIGHT_WIDTH,
   localparam int unsigned LEVELS = $clog2(KERNEL_SIZE),
   localparam int unsigned SUM_W  = PROD_W + LEVELS,
   localparam int unsigned ACC_W  = ((SUM_W > BIAS_WIDTH) ? SUM_W : BIAS_WIDTH) + 1
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [KERNEL_SIZE*PROD_W-1:0] in_data,
   input  logic [BIAS_WIDTH-1:0]         in_bias,
   input  logic [SHIFT_WIDTH-1:0]        in_shift,
   input  logic                          in_relu,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [OUT_WIDTH-1:0]          out_data,
   output logic [ACC_W-1:0]              out_sum,
   output logic                          out_sat
);

   localparam int unsigned WIDE_W = ACC_W + 1;

   localparam logic signed [ACC_W-1:0] SAT_HI = SIGNED ?
      ACC_W'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1) :
      ACC_W'((64'sd1 <<< OUT_WIDTH) - 64'sd1);
   localparam logic signed [ACC_W-1:0] SAT_LO = SIGNED ?
      ACC_W'(-(64'sd1 <<< (OUT_WIDTH - 1))) : ACC_W'(0);

   // Number of live operands after lvl pairwise-add levels (odd leftovers pass through).
   function automatic int unsigned lvl_cnt(input int unsigned lvl);
      int unsigned n;
      n = KERNEL_SIZE;
      for (int unsigned i = 0; i < lvl; i++) n = (n + 1) / 2;
      return n;
   endfunction

   function automatic logic signed [ACC_W-1:0] ext_prod(input logic [PROD_W-1:0] p);
      if (SIGNED) return ACC_W'($signed(p));
      else        return ACC_W'(p);
   endfunction

   function automatic logic signed [ACC_W-1:0] ext_bias(input logic [BIAS_WIDTH-1:0] b);
      if (SIGNED) return ACC_W'($signed(b));
      else        return ACC_W'(b);
   endfunction

   logic advance;
   logic accept;

   logic                    vld      [LEVELS+1];
   logic signed [ACC_W-1:0] ops      [LEVELS+1][KERNEL_SIZE];
   logic [BIAS_WIDTH-1:0]   sb_bias  [LEVELS];
   logic [SHIFT_WIDTH-1:0]  sb_shift [LEVELS+1];
   logic                    sb_relu  [LEVELS+1];

   logic                    pa_vld;
   logic signed [ACC_W-1:0] pa_acc;
   logic signed [ACC_W-1:0] pa_r;
   logic                    pa_relu;

   logic signed [ACC_W-1:0]  tree_sum;
   logic [SHIFT_WIDTH-1:0]   tree_shift;
   logic signed [WIDE_W-1:0] half;
   logic signed [ACC_W-1:0]  round_r;
   logic signed [ACC_W-1:0]  relu_r;
   logic signed [ACC_W-1:0]  clamp_r;
   logic                     clamp_sat;

   // Single global stall: everything moves only when the output slot frees up.
   assign advance  = !out_valid || out_ready;
   assign in_ready = advance && rstn;
   assign accept   = in_valid && in_ready;

   // Stage 0: capture products and sideband of the accepted beat.
   always_ff @(posedge clk) begin
      if (!rstn)        vld[0] <= 1'b0;
      else if (advance) vld[0] <= in_valid;
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         sb_bias[0]  <= in_bias;
         sb_shift[0] <= in_shift;
         sb_relu[0]  <= in_relu;
      end
   end

   for (genvar j = 0; j < KERNEL_SIZE; j++) begin : g_in
      always_ff @(posedge clk) begin
         if (accept) ops[0][j] <= ext_prod(in_data[j*PROD_W +: PROD_W]);
      end
   end

   // Tree levels: pairwise adds, bias folded into the final pair.
   for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
      localparam int unsigned NP = lvl_cnt(l - 1);
      localparam int unsigned NC = lvl_cnt(l);

      logic signed [ACC_W-1:0] bias_term;

      always_ff @(posedge clk) begin
         if (!rstn)        vld[l] <= 1'b0;
         else if (advance) vld[l] <= vld[l-1];
      end

      always_ff @(posedge clk) begin
         if (advance && vld[l-1]) begin
            sb_shift[l] <= sb_shift[l-1];
            sb_relu[l]  <= sb_relu[l-1];
         end
      end

      if (l == LEVELS) begin : g_last
         assign bias_term = ext_bias(sb_bias[l-1]);
      end else begin : g_mid
         assign bias_term = '0;
         always_ff @(posedge clk) begin
            if (advance && vld[l-1]) sb_bias[l] <= sb_bias[l-1];
         end
      end

      for (genvar j = 0; j < NC; j++) begin : g_op
         if (2*j + 1 < NP) begin : g_add
            always_ff @(posedge clk) begin
               if (advance && vld[l-1])
                  ops[l][j] <= ops[l-1][2*j] + ops[l-1][2*j+1] + bias_term;
            end
         end else begin : g_pass
            always_ff @(posedge clk) begin
               if (advance && vld[l-1]) ops[l][j] <= ops[l-1][2*j];
            end
         end
      end
   end

   assign tree_sum   = ops[LEVELS][0];
   assign tree_shift = sb_shift[LEVELS];

   // Round-half-up arithmetic right shift, computed one bit wider to absorb the half.
   always_comb begin : round_shift
      round_r = tree_sum;
      half    = '0;
      if (tree_shift == '0) begin
         round_r = tree_sum;
      end else if (32'(tree_shift) >= ACC_W) begin
         round_r = tree_sum[ACC_W-1] ? '1 : '0;
      end else begin
         half    = WIDE_W'(1) << (tree_shift - SHIFT_WIDTH'(1));
         round_r = ACC_W'(($signed({tree_sum[ACC_W-1], tree_sum}) + half) >>> tree_shift);
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn)        pa_vld <= 1'b0;
      else if (advance) pa_vld <= vld[LEVELS];
   end

   always_ff @(posedge clk) begin
      if (advance && vld[LEVELS]) begin
         pa_acc  <= tree_sum;
         pa_r    <= round_r;
         pa_relu <= SIGNED && sb_relu[LEVELS];
      end
   end

   // ReLU zeroes negatives without flagging saturation; clamp flags only real changes.
   always_comb begin : relu_sat
      relu_r    = pa_r;
      clamp_r   = pa_r;
      clamp_sat = 1'b0;
      if (pa_relu && pa_r[ACC_W-1]) relu_r = '0;
      clamp_r = relu_r;
      if (relu_r > SAT_HI) begin
         clamp_r   = SAT_HI;
         clamp_sat = 1'b1;
      end else if (relu_r < SAT_LO) begin
         clamp_r   = SAT_LO;
         clamp_sat = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sum   <= '0;
         out_sat   <= 1'b0;
      end else if (advance) begin
         out_valid <= pa_vld;
         if (pa_vld) begin
            out_data <= OUT_WIDTH'(clamp_r);
            out_sum  <= pa_acc;
            out_sat  <= clamp_sat;
         end
      end
   end

endmodule

// File: tb/tb_conv_accum_tree.sv
// Directed + randomized bench for conv_accum_tree (K=9, signed, 8-bit output)
// with an arithmetic reference model and an expected-result queue.
module tb_conv_accum_tree;

   localparam int K   = 9;
   localparam int PW  = 16;
   localparam int BW  = 16;
   localparam int SW  = 5;
   localparam int OW  = 8;
   localparam int AW  = 21;
   localparam int LAT = 6;

   logic            clk;
   logic            rstn;
   logic            in_valid;
   logic            in_ready;
   logic [K*PW-1:0] in_data;
   logic [BW-1:0]   in_bias;
   logic [SW-1:0]   in_shift;
   logic            in_relu;
   logic            out_valid;
   logic            out_ready;
   logic [OW-1:0]   out_data;
   logic [AW-1:0]   out_sum;
   logic            out_sat;

   conv_accum_tree dut (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_bias   (in_bias),
      .in_shift  (in_shift),
      .in_relu   (in_relu),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sum   (out_sum),
      .out_sat   (out_sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      longint sum;
      longint data;
      bit     sat;
      int     acc_cyc;
   } exp_t;

   exp_t   expq[$];
   longint drv_prod [K];
   longint drv_bias;
   int     drv_shift;
   bit     drv_relu;
   bit     drv_valid;
   bit     drv_ready;
   bit     lat_check;
   bit     last_acc;
   int     cycnum;
   int     n_checks;
   int     n_pass;
   int     n_fail;
   int     sent;

   task automatic check(input string tag, input logic signed [63:0] obs,
                        input logic signed [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: exact sum, floor((acc + 2^(s-1)) / 2^s), relu, clamp to int8.
   function automatic exp_t model();
      exp_t   e;
      longint acc, r, num, d;
      acc = drv_bias;
      for (int j = 0; j < K; j++) acc += drv_prod[j];
      if (drv_shift == 0) begin
         r = acc;
      end else if (drv_shift >= AW) begin
         r = (acc < 0) ? -1 : 0;
      end else begin
         d   = longint'(1) << drv_shift;
         num = acc + d / 2;
         r   = num / d;
         if ((num % d != 0) && (num < 0)) r = r - 1;
      end
      if (drv_relu && r < 0) r = 0;
      e.sum = acc;
      e.sat = 1'b0;
      if (r > 127) begin
         r = 127;
         e.sat = 1'b1;
      end else if (r < -128) begin
         r = -128;
         e.sat = 1'b1;
      end
      e.data    = r;
      e.acc_cyc = 0;
      return e;
   endfunction

   // One clock: observe outputs, drive inputs, book-keep handshake, advance.
   task automatic cyc();
      exp_t e;
      if (rstn) begin
         if (expq.size() == 0) begin
            check("idle_valid", out_valid, 0);
         end else if (out_valid) begin
            e = expq[0];
            check("out_sum", 64'($signed(out_sum)), e.sum);
            check("out_data", 64'($signed(out_data)), e.data);
            check("out_sat", out_sat, e.sat);
            if (lat_check) check("latency", cycnum - e.acc_cyc, LAT);
         end
      end
      in_valid  = drv_valid;
      out_ready = drv_ready;
      in_bias   = BW'(drv_bias);
      in_shift  = SW'(drv_shift);
      in_relu   = drv_relu;
      for (int j = 0; j < K; j++)
         in_data[j*PW +: PW] = drv_valid ? PW'(drv_prod[j]) : PW'($urandom);
      #1;
      if (rstn) begin
         if (out_valid && !drv_ready) check("in_ready_stall", in_ready, 0);
         if (drv_ready) check("in_ready_open", in_ready, 1);
      end else begin
         check("in_ready_rst", in_ready, 0);
      end
      last_acc = in_valid && in_ready;
      if (rstn) begin
         if (out_valid && drv_ready && expq.size() > 0) void'(expq.pop_front());
         if (last_acc) begin
            e = model();
            e.acc_cyc = cycnum + 1;
            expq.push_back(e);
         end
      end
      @(posedge clk);
      cycnum++;
      if (!rstn) expq.delete();
      #1;
   endtask

   task automatic idle(input int n);
      drv_valid = 1'b0;
      repeat (n) cyc();
   endtask

   task automatic beat();
      drv_valid = 1'b1;
      cyc();
      drv_valid = 1'b0;
   endtask

   task automatic set_const(input longint p, input longint b, input int sh, input bit relu);
      for (int j = 0; j < K; j++) drv_prod[j] = p;
      drv_bias  = b;
      drv_shift = sh;
      drv_relu  = relu;
   endtask

   task automatic set_one(input longint p, input longint b, input int sh, input bit relu);
      set_const(0, b, sh, relu);
      drv_prod[0] = p;
   endtask

   task automatic set_rand();
      for (int j = 0; j < K; j++) begin
         case ($urandom_range(0, 5))
            0:       drv_prod[j] = 32767;
            1:       drv_prod[j] = -32768;
            default: drv_prod[j] = longint'($signed(16'($urandom)));
         endcase
      end
      drv_bias  = longint'($signed(16'($urandom)));
      drv_shift = int'($urandom_range(0, 31));
      drv_relu  = 1'($urandom);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks  = 0;
      n_pass    = 0;
      n_fail    = 0;
      cycnum    = 0;
      lat_check = 1'b1;
      rstn      = 1'b0;
      drv_valid = 1'b0;
      drv_ready = 1'b1;
      set_const(0, 0, 0, 0);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      in_data   = '0;
      in_bias   = '0;
      in_shift  = '0;
      in_relu   = 1'b0;
      @(posedge clk);
      #1;
      cyc();
      cyc();
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_sum", out_sum, 0);
      check("rst_out_sat", out_sat, 0);
      rstn = 1'b1;

      // All-ones products, then positive/negative overflow.
      set_const(1, 0, 0, 0);
      beat();
      idle(8);
      set_const(16384, 0, 0, 0);
      beat();
      set_const(-32768, 0, 0, 0);
      beat();
      idle(8);

      // Rounding and bias.
      set_one(6, 0, 2, 0);   beat();
      set_one(5, 0, 2, 0);   beat();
      set_one(-6, 0, 2, 0);  beat();
      set_one(-7, 0, 1, 0);  beat();
      set_one(4, -10, 0, 0); beat();
      set_one(1, 0, 25, 0);  beat();
      set_one(-1, 0, 25, 0); beat();
      idle(8);

      // ReLU on and off for the same negative value.
      set_one(-20, 0, 0, 1); beat();
      set_one(-20, 0, 0, 0); beat();
      idle(8);

      // Random beats with random bubbles, no backpressure.
      repeat (40) begin
         set_rand();
         drv_valid = ($urandom_range(0, 3) != 0);
         cyc();
      end
      idle(8);

      // Twelve distinct beats with two 3-cycle output stalls.
      lat_check = 1'b0;
      sent = 0;
      for (int c = 0; c < 300 && (sent < 12 || expq.size() > 0); c++) begin
         drv_ready = !((c >= 8 && c <= 10) || (c >= 14 && c <= 16));
         if (sent < 12) begin
            for (int j = 0; j < K; j++) drv_prod[j] = sent * 7 + j;
            drv_bias  = -3 * sent;
            drv_shift = 1;
            drv_relu  = 1'b0;
            drv_valid = 1'b1;
         end else begin
            drv_valid = 1'b0;
         end
         cyc();
         if (last_acc) sent++;
      end
      check("stream_sent", sent, 12);
      check("stream_drained", expq.size(), 0);
      drv_ready = 1'b1;
      lat_check = 1'b1;
      idle(2);

      // Mid-stream reset discards three in-flight beats.
      for (int i = 0; i < 3; i++) begin
         set_rand();
         beat();
      end
      idle(1);
      rstn = 1'b0;
      cyc();
      rstn = 1'b1;
      check("rst_mid_valid", out_valid, 0);
      idle(10);
      set_const(2, 5, 0, 0);
      beat();
      idle(8);

      for (int i = 0; i < 50 && expq.size() > 0; i++) cyc();
      check("final_drain", expq.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
